// File: rtl/i2s_cap_pkg.sv
// Shared types and slot-position constants for the multi-line I2S capture block.
package i2s_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_e;

    localparam int SLOT_BITS   = 32;
    localparam int LEFT_FIRST  = 1;
    localparam int RIGHT_FIRST = 33;

endpackage

// File: rtl/i2s_cap_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry, zero when empty.
module i2s_cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = ((wptr_q - rptr_q) == (AW + 1)'(DEPTH));
    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2s_capture_mc.sv
// Multi-line I2S capture: slot counter on synced sck falls, per-line L/R shift registers, block FSM, FIFO.
// Define I2S_CAP_OVF_CNT_EN to add the 16-bit saturating dropped-frame counter on ovf_count.
module i2s_capture_mc
    import i2s_cap_pkg::*;
#(
    parameter int NUM_LINES  = 2,
    parameter int SAMPLE_W   = 24,
    parameter int STORE_W    = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sck,
    input  logic [NUM_LINES-1:0]           sd,
    input  logic                           start,
    input  logic                           continuous,
    input  logic                           stop,
    output logic                           ws,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [2*NUM_LINES*STORE_W-1:0] m_data,
    output logic                           m_last
`ifdef I2S_CAP_OVF_CNT_EN
    ,
    output logic [15:0]                    ovf_count
`endif
);
    localparam int CNT_W  = $clog2(2 * SLOT_BITS);
    localparam int DATA_W = 2 * NUM_LINES * STORE_W;
    localparam int FRM_W  = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] L_LO    = CNT_W'(LEFT_FIRST);
    localparam logic [CNT_W-1:0] L_HI    = CNT_W'(LEFT_FIRST + SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] R_LO    = CNT_W'(RIGHT_FIRST);
    localparam logic [CNT_W-1:0] R_HI    = CNT_W'(RIGHT_FIRST + SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] PUSH_AT = CNT_W'(RIGHT_FIRST + SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cap_state_e          state_q, state_d;
    logic                sck_meta_q, sck_meta_d;
    logic                sck_sync_q, sck_sync_d;
    logic                sck_prev_q, sck_prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] l_sr_q [NUM_LINES];
    logic [SAMPLE_W-1:0] l_sr_d [NUM_LINES];
    logic [SAMPLE_W-1:0] r_sr_q [NUM_LINES];
    logic [SAMPLE_W-1:0] r_sr_d [NUM_LINES];
    logic [FRM_W-1:0]    frame_q, frame_d;
    logic                cont_q, cont_d;
    logic                ovf_q, ovf_d;

    logic                fall;
    logic                in_left;
    logic                in_right;
    logic                start_acc;
    logic                push_req;
    logic                last_frame;
    logic                drop;
    logic [DATA_W-1:0]   push_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;

    assign fall       = sck_prev_q && !sck_sync_q;
    assign in_left    = (cnt_q >= L_LO) && (cnt_q <= L_HI);
    assign in_right   = (cnt_q >= R_LO) && (cnt_q <= R_HI);
    assign start_acc  = (state_q == IDLE) && start && !stop;
    assign last_frame = (frame_q == FRM_W'(FRAME_LEN - 1));
    // stop on the push slot wins: the aborted frame is never queued.
    assign push_req   = (state_q == CAPTURE) && fall && (cnt_q == PUSH_AT) && !stop;
    assign fifo_pop   = m_valid && m_ready;
    assign drop       = push_req && fifo_full && !fifo_pop;
    assign ws         = cnt_q[CNT_W-1];
    assign overflow   = ovf_q;
    assign m_valid    = !fifo_empty;

    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            push_data[(2*i)*STORE_W   +: STORE_W] = l_sr_q[i][SAMPLE_W-1 -: STORE_W];
            push_data[(2*i+1)*STORE_W +: STORE_W] = r_sr_q[i][SAMPLE_W-1 -: STORE_W];
        end
    end

    always_comb begin
        sck_meta_d = sck;
        sck_sync_d = sck_meta_q;
        sck_prev_d = sck_sync_q;
        cnt_d      = fall ? cnt_q + 1'b1 : cnt_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            l_sr_d[i] = (fall && in_left)  ? SAMPLE_W'({l_sr_q[i], sd[i]}) : l_sr_q[i];
            r_sr_d[i] = (fall && in_right) ? SAMPLE_W'({r_sr_q[i], sd[i]}) : r_sr_q[i];
        end
        cont_d  = start_acc ? continuous : cont_q;
        ovf_d   = start_acc ? 1'b0 : (ovf_q || drop);
        frame_d = frame_q;
        if (start_acc) frame_d = '0;
        else if (push_req) frame_d = last_frame ? '0 : frame_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            cnt_q      <= '0;
            frame_q    <= '0;
            cont_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                l_sr_q[i] <= '0;
                r_sr_q[i] <= '0;
            end
        end else begin
            sck_meta_q <= sck_meta_d;
            sck_sync_q <= sck_sync_d;
            sck_prev_q <= sck_prev_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            cont_q     <= cont_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < NUM_LINES; i++) begin
                l_sr_q[i] <= l_sr_d[i];
                r_sr_q[i] <= r_sr_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ARM only releases on the 63->0 wrap so the first captured frame is always whole.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = ARM;
            ARM:     if (stop) state_d = DRAIN;
                     else if (fall && (cnt_q == CNT_MAX)) state_d = CAPTURE;
            CAPTURE: if (stop) state_d = DRAIN;
                     else if (push_req && last_frame && !cont_q) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DRAIN) && fifo_empty;
    end

    i2s_cap_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata ({last_frame, push_data}),
        .pop   (fifo_pop),
        .rdata ({m_last, m_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef I2S_CAP_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (start_acc) ovf_cnt_d = '0;
        else if (drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_cnt_q <= '0;
        else        ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_capture_mc.sv
// Directed bench for i2s_capture_mc: sck = clk/8, two lines, FRAME_LEN=4, FIFO_DEPTH=4.
module tb_i2s_capture_mc;

    logic        clk;
    logic        rst_n;
    logic        sck;
    logic [1:0]  sd;
    logic        start;
    logic        continuous;
    logic        stop;
    logic        ws;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
`ifdef I2S_CAP_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          ph = 0;
    int          fr = 0;
    int          base = 0;
    logic [5:0]  bc = '0;
    logic [63:0] q_data [$];
    logic        q_last [$];

    i2s_capture_mc #(
        .NUM_LINES  (2),
        .SAMPLE_W   (24),
        .STORE_W    (16),
        .FRAME_LEN  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .sd         (sd),
        .start      (start),
        .continuous (continuous),
        .stop       (stop),
        .ws         (ws),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef I2S_CAP_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] lval(int line, int f);
        return 24'hABCDEF + 24'(f * 273) + 24'(line * 32'h100000);
    endfunction

    function automatic logic [23:0] rval(int line, int f);
        return 24'h123456 + 24'(f * 546) + 24'(line * 32'h200000);
    endfunction

    function automatic logic bit_for(int line, logic [5:0] c, int f);
        logic [23:0] l;
        logic [23:0] r;
        int ci;
        ci = int'(c);
        l  = lval(line, f);
        r  = rval(line, f);
        if (ci >= 1 && ci <= 24)  return l[24 - ci];
        if (ci >= 33 && ci <= 56) return r[56 - ci];
        return 1'b0;
    endfunction

    function automatic logic [63:0] exp_word(int f);
        logic [23:0] l0, r0, l1, r1;
        l0 = lval(0, f);
        r0 = rval(0, f);
        l1 = lval(1, f);
        r1 = rval(1, f);
        return {r1[23:8], l1[23:8], r0[23:8], l0[23:8]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // I2S source: data changes on sck rise, bc mirrors the DUT slot count seen at each fall.
    initial begin
        sck = 1'b0;
        sd  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph  = 0;
                sck = 1'b0;
                bc  = '0;
            end else begin
                ph = (ph + 1) % 8;
                if (ph == 4) begin
                    sck = 1'b1;
                    for (int i = 0; i < 2; i++) sd[i] = bit_for(i, bc, fr - base);
                end else if (ph == 0) begin
                    sck = 1'b0;
                    bc  = bc + 6'd1;
                    if (bc == 6'd0) fr++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_last.push_back(m_last);
            end
            if (done) n_done++;
        end
    end

    task automatic arm(input logic cont);
        int n = 0;
        while (bc != 6'd40 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        base       = fr + 1;
        continuous = cont;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_words(input int cnt, input int budget);
        int n = 0;
        while (q_data.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int d0;
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        m_ready    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_ws", 64'(ws), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_data", m_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // start together with stop in IDLE is ignored
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("startstop_busy", 64'(busy), 64'd0);

        // one-shot block, armed mid-frame at slot 40
        q_data.delete();
        q_last.delete();
        d0 = n_done;
        arm(1'b0);
        @(negedge clk);
        check("a_busy", 64'(busy), 64'd1);
        wait_idle("a_idle", 4000);
        check("a_words", 64'(q_data.size()), 64'd4);
        if (q_data.size() == 4) begin
            check("a_first_lo32", 64'(q_data[0][31:0]), 64'h1234_ABCD);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("a_data%0d", k), q_data[k], exp_word(k));
                check($sformatf("a_last%0d", k), 64'(q_last[k]), 64'(k == 3));
            end
        end
        check("a_done_pulses", 64'(n_done - d0), 64'd1);

        // continuous mode, stop after 10 frames
        q_data.delete();
        q_last.delete();
        d0 = n_done;
        arm(1'b1);
        wait_words(10, 7000);
        check("b_busy_before_stop", 64'(busy), 64'd1);
        pulse_stop();
        wait_idle("b_idle", 2000);
        check("b_words", 64'(q_data.size()), 64'd10);
        if (q_data.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                check($sformatf("b_data%0d", k), q_data[k], exp_word(k));
                check($sformatf("b_last%0d", k), 64'(q_last[k]), 64'(k == 3 || k == 7));
            end
        end
        check("b_done_pulses", 64'(n_done - d0), 64'd1);

        // overflow: sink stalled for 6 frames, two frames dropped
        q_data.delete();
        q_last.delete();
        d0 = n_done;
        m_ready = 1'b0;
        arm(1'b1);
        n = 0;
        while (!((fr - base) >= 6 && bc >= 6'd2) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        pulse_stop();
        repeat (4) @(negedge clk);
        check("c_ovf", 64'(overflow), 64'd1);
        check("c_busy_drain", 64'(busy), 64'd1);
        check("c_valid", 64'(m_valid), 64'd1);
`ifdef I2S_CAP_OVF_CNT_EN
        check("c_ovf_count", 64'(ovf_count), 64'd2);
`endif
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle("c_idle", 200);
        check("c_words", 64'(q_data.size()), 64'd4);
        if (q_data.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("c_data%0d", k), q_data[k], exp_word(k));
                check($sformatf("c_last%0d", k), 64'(q_last[k]), 64'(k == 3));
            end
        end
        check("c_ovf_sticky", 64'(overflow), 64'd1);
        check("c_done_pulses", 64'(n_done - d0), 64'd1);

        // reset mid-capture with a buffered frame
        q_data.delete();
        q_last.delete();
        m_ready = 1'b0;
        arm(1'b0);
        @(negedge clk);
        check("d_ovf_cleared", 64'(overflow), 64'd0);
`ifdef I2S_CAP_OVF_CNT_EN
        check("d_ovf_count_cleared", 64'(ovf_count), 64'd0);
`endif
        n = 0;
        while (m_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("d_valid_before", 64'(m_valid), 64'd1);
        check("d_busy_before", 64'(busy), 64'd1);
        d0 = n_done;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("d_valid_after", 64'(m_valid), 64'd0);
        check("d_busy_after", 64'(busy), 64'd0);
        check("d_data_after", m_data, 64'd0);
        repeat (600) @(negedge clk);
        check("d_no_done", 64'(n_done - d0), 64'd0);
        check("d_valid_late", 64'(m_valid), 64'd0);
        check("d_busy_late", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_capture_mc.md
I2S_CAPTURE_MC -- requirements
Module: i2s_capture_mc

Interface
REQ-001 SHALL have parameter NUM_LINES, default 2: number of I2S data lines, each carrying a stereo pair.
REQ-002 SHALL have parameter SAMPLE_W, default 24: valid bits per slot, MSB first, legal range 1..30.
REQ-003 SHALL have parameter STORE_W, default 16: MSBs kept per sample, STORE_W <= SAMPLE_W.
REQ-004 SHALL have parameter FRAME_LEN, default 1024: stereo frames per capture block.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-006 SHALL use clock clk and reset rst_n, where rst_n is synchronous and active-low.
REQ-007 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  system clock, at least 4x sck
- rst_n  in  1  synchronous active-low reset
- sck  in  1  asynchronous I2S bit clock
- sd  in  NUM_LINES  serial data, one bit per line
- start  in  1  one-cycle pulse that arms a capture
- continuous  in  1  sampled at start; 1 repeats blocks
- stop  in  1  one-cycle pulse that aborts a capture
- ws  out  1  word select
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE
- overflow  out  1  sticky flag: a frame was dropped
- m_valid  out  1  output word valid
- m_ready  in  1  sink accepts the output word
- m_data  out  2*NUM_LINES*STORE_W  packed output frame
- m_last  out  1  marks the final frame of a block

Function
REQ-008 SHALL pass sck through a 2-flop synchronizer; a fall event is a synced previous value of 1 followed by a current value of 0.
REQ-009 SHALL keep a 6-bit slot counter that increments on each fall event and wraps from 63 to 0; ws SHALL equal counter bit 5.
REQ-010 SHALL, on a fall event with the pre-increment count in 1..SAMPLE_W, shift each sd[i] into the left shift register of line i.
REQ-011 SHALL, on a fall event with the pre-increment count in 33..32+SAMPLE_W, shift each sd[i] into the right shift register of line i.
REQ-012 SHALL pack m_data as word k at bits [k*STORE_W +: STORE_W], with k=2i for line i left and k=2i+1 for line i right; each word is the STORE_W MSBs of its SAMPLE_W register.
REQ-013 FSM states SHALL be IDLE, ARM, CAPTURE, DRAIN.
REQ-014 IDLE SHALL go to ARM on start and SHALL latch continuous, clear overflow and clear the frame count at that point.
REQ-015 ARM SHALL go to CAPTURE on the fall event where the count wraps from 63 to 0, so capture always begins at a frame boundary.
REQ-016 CAPTURE SHALL push one frame into the FIFO on the fall event at count 33+SAMPLE_W and SHALL increment the frame count.
REQ-017 The push of frame number FRAME_LEN SHALL carry last=1 and reset the frame count; with continuous=0 the FSM SHALL then go to DRAIN, otherwise it SHALL stay in CAPTURE.
REQ-018 DRAIN SHALL go to IDLE when the FIFO is empty, and done SHALL pulse in that same cycle.
REQ-019 stop in ARM or CAPTURE SHALL go to DRAIN with no further pushes; stop in any other state SHALL be ignored.
REQ-020 start while busy=1 SHALL be ignored; start and stop in the same cycle in IDLE SHALL leave the FSM in IDLE.
REQ-021 A push with the FIFO full SHALL drop the frame and set overflow; the frame still counts toward FRAME_LEN.
REQ-022 m_valid, m_data and m_last SHALL present the FIFO head, and a pop SHALL occur when m_valid=1 and m_ready=1.
REQ-023 A simultaneous push and pop on a full FIFO SHALL be accepted with no overflow.
REQ-024 Latency from the push fall event to m_valid SHALL be 1 clk when the FIFO is empty.

Reset
REQ-025 rst_n=0 SHALL force the FSM to IDLE and clear the slot counter, shift registers, FIFO pointers, synchronizer and frame count.
REQ-026 During rst_n=0, outputs SHALL read ws=0, busy=0, done=0, overflow=0, m_valid=0, m_last=0 and m_data=0.
REQ-027 Reset asserted mid-capture SHALL discard all buffered frames without asserting done.

Configuration
REQ-028 Macro I2S_CAP_OVF_CNT_EN SHALL, when defined, add output port ovf_count (16 bits): a saturating count of dropped frames, cleared by reset and by an accepted start.
REQ-029 When I2S_CAP_OVF_CNT_EN is undefined, the ovf_count port and its counter SHALL be absent; the overflow flag SHALL remain in both builds.

Structure
REQ-030 Package i2s_cap_pkg SHALL hold the FSM state enum and the constants SLOT_BITS=32, LEFT_FIRST=1 and RIGHT_FIRST=33.
REQ-031 The FIFO SHALL be sub-module i2s_cap_fifo: synchronous, show-ahead, with full/empty flags, parameterised by width and depth.

Verification
REQ-032 Bench SHALL cover basic capture: defaults, sck = clk/8, line0 L=0xABCDEF, R=0x123456, m_ready=1 -> first word low 32 bits 0x1234_ABCD.
REQ-033 Bench SHALL cover one-shot block length: FRAME_LEN=4, continuous=0 -> exactly 4 words, m_last on the 4th, done pulse once, busy low afterwards.
REQ-034 Bench SHALL cover continuous mode: continuous=1 for 10 frames with FRAME_LEN=4 -> m_last on words 4 and 8, then stop -> DRAIN -> done.
REQ-035 Bench SHALL cover overflow: m_ready=0 for 6 frames, FIFO_DEPTH=4 -> 4 words retained, overflow=1, and ovf_count=2 with the macro defined.
REQ-036 Bench SHALL cover mid-frame arming: start issued at slot count 40 -> no push until a full frame has been captured starting from count 0.
REQ-037 Bench SHALL cover reset mid-capture: rst_n low for 1 cycle during CAPTURE -> m_valid=0, busy=0, no done pulse.
